alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter EXEC_CYC, default 1, the number of execute cycles per operation; legal range 1..4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 SHALL have ports req_valid[i], input, 1 bit, for i=0,1: requester i presents an operation.
REQ-005 SHALL have ports req_ready[i], output, 1 bit: the operation of requester i is accepted this cycle.
REQ-006 SHALL have ports req_a[i] and req_b[i], input, 32 bits each: operands of requester i, signed two's complement.
REQ-007 SHALL have ports req_op[i], input, 4 bits: the opcode of requester i.
REQ-008 SHALL have ports resp_valid[i], output, 1 bit: a result for requester i is available.
REQ-009 SHALL have ports resp_ready[i], input, 1 bit: requester i takes its result.
REQ-010 SHALL have port resp_res, output, 32 bits: the result value, shared by both requesters.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, EXEC and RESP, with at most one operation in flight.
REQ-013 In IDLE with any req_valid high, SHALL assert req_ready for exactly one granted requester in that cycle (combinational), latch that requester's a, b and op, and go to EXEC.
REQ-014 Grant SHALL be round-robin: when both requesters are valid, the requester not granted most recently wins; after reset, requester 0 has priority.
REQ-015 req_ready SHALL be low in EXEC and RESP, and low for the losing requester.
REQ-016 EXEC SHALL last exactly EXEC_CYC cycles, counted by an internal counter; the result SHALL be registered into resp_res at EXEC exit and the FSM then goes to RESP.
REQ-017 Opcodes 0-9 SHALL compute, in order:
  - A+B, A-B, A&B, A|B, A^B
  - A<<B[4:0] (logical), A>>B[4:0] (logical)
  - A+1, A-1, ~A
REQ-018 Opcodes 10-15 SHALL compute the same functions as opcodes 0-5; all arithmetic wraps modulo 2^32 with no overflow flag.
REQ-019 Shift amounts SHALL use only B[4:0]; B[31:5] SHALL be ignored.
REQ-020 In RESP, resp_valid SHALL be high only for the granted requester, and resp_res SHALL stay stable until the handshake (resp_valid & resp_ready).
REQ-021 On the response handshake the FSM SHALL return to IDLE; a new grant is possible no earlier than the next cycle.
REQ-022 Minimum turnaround SHALL be EXEC_CYC+2 cycles from acceptance to the next acceptance.
REQ-023 Changes on req_a, req_b or req_op after acceptance SHALL NOT affect the in-flight result.
REQ-024 A requester dropping req_valid without having received req_ready SHALL lose nothing: there is no grant and no state change.

Reset
REQ-025 While rst is high at a clock edge, the FSM SHALL go to IDLE, the counter to 0, resp_res to 0, the round-robin pointer to favour requester 0, and busy, all req_ready and all resp_valid to 0.
REQ-026 Reset in EXEC or RESP SHALL abort the in-flight operation with no response issued; the first grant after reset follows REQ-014.

Verification
REQ-027 Reset then idle: all outputs 0 and busy=0; req0 op=0, a=5, b=-7 -> req_ready[0] in the same cycle; resp_valid[0] with resp_res=0xFFFFFFFE after EXEC_CYC+1 cycles.
REQ-028 Both requesters valid continuously with resp_ready=1: grants alternate 0,1,0,1; each result pairs with its own operands.
REQ-029 Opcode sweep with a=0x80000001, b=0x00000021: op5 -> 0x00000002, op6 -> 0x40000000, op7 -> 0x80000002, op9 -> 0x7FFFFFFE, op13 -> 0x80000021.
REQ-030 Hold resp_ready[0]=0 for 5 cycles in RESP: resp_res stays stable, no new grant occurs and req1 waits; on release, the grant goes to req1.
REQ-031 Assert rst in the 2nd EXEC cycle with EXEC_CYC=3: no resp_valid follows; after reset, req0 and req1 both valid -> req0 granted.
REQ-032 Wrap-around: op0 with a=0x7FFFFFFF, b=1 -> 0x80000000; op8 with a=0x80000000 -> 0x7FFFFFFF.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_arbiter                                                |
// | Description : Two-requester round-robin front end to a single multi-     |
// |               cycle 32-bit ALU. One operation in flight at a time:       |
// |               IDLE -> EXEC (EXEC_CYC cycles) -> RESP -> IDLE.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk             : clock, all state changes on rising edge              |
// |   rst             : synchronous active-high reset                        |
// |   req_valid[1:0]  : requester i presents an operation                    |
// |   req_ready[1:0]  : requester i accepted this cycle (combinational)      |
// |   req_a[i]        : 32-bit operand A of requester i                      |
// |   req_b[i]        : 32-bit operand B of requester i                      |
// |   req_op[i]       : 4-bit opcode of requester i                          |
// |   resp_valid[1:0] : result available for requester i                     |
// |   resp_ready[1:0] : requester i takes its result                         |
// |   resp_res        : 32-bit result, shared by both requesters             |
// |   busy            : high whenever the FSM is not in IDLE                 |
// +--------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int EXEC_CYC = 1  // execute cycles per operation, 1..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  input  logic [1:0][3:0]  req_op,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_res,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Last value of the execute counter before leaving EXEC.
  localparam logic [1:0] CNT_LAST = 2'(EXEC_CYC - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic        prio_q,  prio_d;   // requester that wins a tie
  logic        gnt_q,   gnt_d;    // requester owning the in-flight op
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [3:0]  op_q,    op_d;
  logic [31:0] res_q,   res_d;

  logic        win;
  logic [31:0] alu_res;
  logic [3:0]  op_eff;

  // Arbitration: a tie goes to the priority pointer, otherwise to whoever
  // is valid (req_valid[1] alone selects 1, anything else selects 0).
  always_comb begin
    win = 1'b0;
    if (&req_valid) begin
      win = prio_q;
    end else begin
      win = req_valid[1];
    end
  end

  // ALU over the latched operands; opcodes 10..15 alias 0..5.
  always_comb begin
    alu_res = '0;
    op_eff  = (op_q >= 4'd10) ? (op_q - 4'd10) : op_q;
    case (op_eff)
      4'd0:    alu_res = a_q + b_q;
      4'd1:    alu_res = a_q - b_q;
      4'd2:    alu_res = a_q & b_q;
      4'd3:    alu_res = a_q | b_q;
      4'd4:    alu_res = a_q ^ b_q;
      4'd5:    alu_res = a_q << b_q[4:0];
      4'd6:    alu_res = a_q >> b_q[4:0];
      4'd7:    alu_res = a_q + 32'd1;
      4'd8:    alu_res = a_q - 32'd1;
      4'd9:    alu_res = ~a_q;
      default: alu_res = '0;
    endcase
  end

  // Next-state and request-side outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    req_ready = '0;

    case (state_q)
      S_IDLE: begin
        // No acceptance is signalled while reset is pending: it would be
        // discarded by the reset at this very edge.
        if ((|req_valid) && !rst) begin
          req_ready[win] = 1'b1;
          gnt_d          = win;
          prio_d         = ~win;
          a_d            = req_a[win];
          b_d            = req_b[win];
          op_d           = req_op[win];
          cnt_d          = '0;
          state_d        = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_LAST) begin
          res_d   = alu_res;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RESP: begin
        if (resp_ready[gnt_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign resp_valid = (state_q == S_RESP) ? (2'b01 << gnt_q) : 2'b00;
  assign resp_res   = res_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_arbiter                                             |
// | Description : Self-checking bench for alu_arbiter with a transaction-    |
// |               level reference model and directed scenarios.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;

  localparam int EC = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][3:0]  req_op;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [31:0]      resp_res;
  logic             busy;

  always #5 clk = ~clk;

  alu_arbiter #(.EXEC_CYC(EC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_res   (resp_res),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction-level model: one op in flight, response due a fixed
  // number of cycles after acceptance.
  bit          m_busy   = 1'b0;
  bit          m_owner  = 1'b0;
  bit          m_last   = 1'b1;   // 1 => requester 0 wins the next tie
  logic [31:0] m_result = '0;
  logic [31:0] m_shown  = '0;
  int          m_resp_cyc = 0;

  logic [1:0]  obs_ready, obs_rvalid;
  logic [31:0] obs_res;
  logic        obs_busy;

  function automatic logic [31:0] alu_model(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int f;
    f = (op > 4'd9) ? int'(op) - 10 : int'(op);
    case (f)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << (b % 32);
      6: return a >> (b % 32);
      7: return a + 32'd1;
      8: return a - 32'd1;
      9: return ~a;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model,
  // then return just after the rising edge so the caller can drive inputs.
  task automatic tick();
    logic [1:0]  e_ready, e_valid;
    logic [31:0] e_res;
    bit          w, in_resp;
    @(negedge clk);
    obs_ready  = req_ready;
    obs_rvalid = resp_valid;
    obs_res    = resp_res;
    obs_busy   = busy;
    w       = (&req_valid) ? ~m_last : req_valid[1];
    e_ready = (!rst && !m_busy && (|req_valid)) ? (2'b01 << w) : 2'b00;
    in_resp = m_busy && (cyc >= m_resp_cyc);
    e_valid = in_resp ? (2'b01 << m_owner) : 2'b00;
    e_res   = in_resp ? m_result : m_shown;
    chk("req_ready",  {30'd0, obs_ready},  {30'd0, e_ready});
    chk("resp_valid", {30'd0, obs_rvalid}, {30'd0, e_valid});
    chk("busy",       {31'd0, obs_busy},   {31'd0, m_busy});
    chk("resp_res",   obs_res,             e_res);
    if (rst) begin
      m_busy  = 1'b0;
      m_last  = 1'b1;
      m_shown = '0;
    end else if (|e_ready) begin
      m_busy     = 1'b1;
      m_owner    = w;
      m_last     = w;
      m_result   = alu_model(req_op[w], req_a[w], req_b[w]);
      m_resp_cyc = cyc + EC + 1;
    end else if (in_resp && resp_ready[m_owner]) begin
      m_busy  = 1'b0;
      m_shown = m_result;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input int idx, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    req_valid[idx] = 1'b1;
    req_op[idx]    = op;
    req_a[idx]     = a;
    req_b[idx]     = b;
    n = 0;
    do begin
      tick();
      n++;
    end while (!obs_ready[idx] && n < 20);
    chk("grant_seen", {31'd0, obs_ready[idx]}, 32'd1);
    // Scramble operands after acceptance; the in-flight result must not move.
    req_valid[idx] = 1'b0;
    req_a[idx]     = ~a;
    req_b[idx]     = a;
    req_op[idx]    = op + 4'd1;
  endtask

  task automatic wait_resp(input int idx, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!obs_rvalid[idx] && n < 20);
    chk("resp_seen", {31'd0, obs_rvalid[idx]}, 32'd1);
  endtask

  task automatic do_op(input int idx, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string name);
    int n;
    grant(idx, op, a, b);
    wait_resp(idx, n);
    chk(name, obs_res, exp);
    resp_ready[idx] = 1'b1;
    tick();
    resp_ready[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, ngr;
    int order [4];
    logic [31:0] held;

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("reset_busy",   {31'd0, obs_busy},   32'd0);
    chk("reset_rvalid", {30'd0, obs_rvalid}, 32'd0);
    chk("reset_res",    obs_res,             32'd0);

    // Pin the model against hand-computed values.
    chk("model_op5",  alu_model(4'd5,  32'h80000001, 32'h21), 32'h00000002);
    chk("model_op13", alu_model(4'd13, 32'h80000001, 32'h21), 32'h80000021);

    // Basic op: 5 + (-7), same-cycle ready, fixed latency.
    req_valid[0] = 1'b1;
    req_op[0]    = 4'd0;
    req_a[0]     = 32'd5;
    req_b[0]     = 32'hFFFFFFF9;
    tick();
    chk("ready_same_cycle", {30'd0, obs_ready}, 32'd1);
    req_valid[0] = 1'b0;
    req_a[0]     = 32'h12345678;
    wait_resp(0, n);
    chk("latency", n, EC + 1);
    chk("add_neg", obs_res, 32'hFFFFFFFE);
    tick();
    tick();
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;

    // Opcode sweep and wrap-around.
    do_op(0, 4'd5,  32'h80000001, 32'h00000021, 32'h00000002, "op5_shl");
    do_op(0, 4'd6,  32'h80000001, 32'h00000021, 32'h40000000, "op6_shr");
    do_op(0, 4'd7,  32'h80000001, 32'h00000021, 32'h80000002, "op7_inc");
    do_op(0, 4'd9,  32'h80000001, 32'h00000021, 32'h7FFFFFFE, "op9_not");
    do_op(0, 4'd13, 32'h80000001, 32'h00000021, 32'h80000021, "op13_or");
    do_op(0, 4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, "op0_wrap");
    do_op(1, 4'd8,  32'h80000000, 32'h00000000, 32'h7FFFFFFF, "op8_wrap");

    // Both requesters valid continuously: grants alternate 0,1,0,1.
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    req_op[0] = 4'd1;  req_a[0] = 32'd100;      req_b[0] = 32'd58;
    req_op[1] = 4'd4;  req_a[1] = 32'h0000F0F0; req_b[1] = 32'h0000FF00;
    ngr = 0;
    for (int t = 0; t < 60 && ngr < 4; t++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (obs_ready[i] && ngr < 4) begin
          order[ngr] = i;
          ngr++;
          req_a[i]  = req_a[i] + 32'd17;
          req_op[i] = req_op[i] + 4'd3;
        end
      end
    end
    chk("rr_count", ngr, 4);
    chk("rr_g0", order[0], 0);
    chk("rr_g1", order[1], 1);
    chk("rr_g2", order[2], 0);
    chk("rr_g3", order[3], 1);
    req_valid = 2'b00;
    for (int t = 0; t < EC + 3; t++) tick();
    resp_ready = 2'b00;

    // Back-pressure on req0's response while req1 waits.
    req_valid = 2'b11;
    req_op[0] = 4'd2;  req_a[0] = 32'hFFFF0000; req_b[0] = 32'h12345678;
    req_op[1] = 4'd10; req_a[1] = 32'd1;        req_b[1] = 32'd2;
    tick();
    chk("bp_grant0", {30'd0, obs_ready}, 32'd1);
    req_valid[0] = 1'b0;
    wait_resp(0, n);
    chk("bp_res", obs_res, 32'h12340000);
    held = obs_res;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("bp_hold_res", obs_res, held);
      chk("bp_no_grant", {30'd0, obs_ready}, 32'd0);
    end
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    tick();
    chk("bp_grant1", {30'd0, obs_ready}, 32'd2);
    req_valid[1] = 1'b0;
    wait_resp(1, n);
    chk("bp_res1", obs_res, 32'd3);
    resp_ready[1] = 1'b1;
    tick();
    resp_ready[1] = 1'b0;

    // Reset in the 2nd EXEC cycle aborts the op; pointer returns to req0.
    grant(1, 4'd1, 32'd10, 32'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("abort_no_resp", {30'd0, obs_rvalid}, 32'd0);
    end
    req_valid = 2'b11;
    req_op[0] = 4'd11; req_a[0] = 32'd9; req_b[0] = 32'd4;
    req_op[1] = 4'd0;  req_a[1] = 32'd1; req_b[1] = 32'd1;
    tick();
    chk("post_reset_grant", {30'd0, obs_ready}, 32'd1);
    req_valid = 2'b00;
    wait_resp(0, n);
    chk("post_reset_res", obs_res, 32'd5);
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
